// File: rtl/acp_tx_rsp.sv
// rtl/acp_tx_rsp.sv - acp0_tx write-request responder issuing one AXI3 INCR burst per request
// Pulls BURST_LEN beats through a 2-entry buffer and checks the B response.
module acp_tx_rsp #(
    parameter int         BURST_LEN = 16,
    parameter logic [3:0] ACP_CACHE = 4'b1111,
    parameter logic [4:0] ACP_USER  = 5'b00001
) (
    input  logic        clk125,
    input  logic        rst,
    input  logic        acp_tx_en,
    output logic        acp_tx_rdy,
    input  logic [31:0] acp_tx_awaddr,
    input  logic [2:0]  acp_tx_awid,
    input  logic [63:0] acp_tx_wdata,
    output logic        acp_tx_wdreq,
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awid,
    output logic [3:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic [3:0]  m_awcache,
    output logic [4:0]  m_awuser,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [63:0] m_wdata,
    output logic [7:0]  m_wstrb,
    output logic [2:0]  m_wid,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [2:0]  m_bid,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic        busy,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    localparam logic [4:0] LP_LEN  = 5'(BURST_LEN);
    localparam logic [4:0] LP_LAST = 5'(BURST_LEN - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_rdy;
    logic        r_awvalid;
    logic [31:0] r_awaddr;
    logic [2:0]  r_awid;
    logic [63:0] r_buf0;
    logic [63:0] r_buf1;
    logic        r_head;
    logic        r_tail;
    logic [1:0]  r_occ;
    logic        r_in_flight;
    logic [4:0]  r_req_cnt;
    logic [4:0]  r_wr_cnt;
    logic [15:0] r_err_cnt;

    logic w_accept;
    logic w_aw_hs;
    logic w_wvalid;
    logic w_pop;
    logic w_last_beat;
    logic w_b_hs;
    logic w_room;
    logic w_wdreq;
    logic w_err_inc;

    assign w_accept    = (r_state == S_IDLE) && r_rdy && acp_tx_en;
    assign w_aw_hs     = r_awvalid && m_awready;
    assign w_wvalid    = (r_occ != 2'd0);
    assign w_pop       = w_wvalid && m_wready;
    assign w_last_beat = (r_wr_cnt == LP_LAST);
    assign w_b_hs      = (r_state == S_RESP) && m_bvalid;

    // A new pull lands two cycles out; issue only if the beat already owed
    // plus what stays buffered after this cycle's pop leaves a free slot.
    assign w_room  = ({1'b0, r_occ} + {2'b00, r_in_flight}) < (3'd2 + {2'b00, w_pop});
    assign w_wdreq = (r_state == S_DATA) && (r_req_cnt < LP_LEN) && w_room;

    assign w_err_inc = (w_accept && (acp_tx_awaddr[2:0] != 3'b000)) ||
                       (w_b_hs && ((m_bresp != 2'b00) || (m_bid != r_awid)));

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)             w_next = S_ADDR;
            S_ADDR:  if (w_aw_hs)              w_next = S_DATA;
            S_DATA:  if (w_pop && w_last_beat) w_next = S_RESP;
            S_RESP:  if (m_bvalid)             w_next = S_IDLE;
            default:                           w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            r_rdy       <= 1'b0;
            r_awvalid   <= 1'b0;
            r_awaddr    <= 32'd0;
            r_awid      <= 3'd0;
            r_buf0      <= 64'd0;
            r_buf1      <= 64'd0;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_occ       <= 2'd0;
            r_in_flight <= 1'b0;
            r_req_cnt   <= 5'd0;
            r_wr_cnt    <= 5'd0;
            r_err_cnt   <= 16'd0;
        end else begin
            r_rdy <= (w_next == S_IDLE);

            if (w_accept) begin
                r_awaddr  <= {acp_tx_awaddr[31:3], 3'b000};
                r_awid    <= acp_tx_awid;
                r_awvalid <= 1'b1;
                r_req_cnt <= 5'd0;
                r_wr_cnt  <= 5'd0;
            end else begin
                if (w_aw_hs) begin
                    r_awvalid <= 1'b0;
                end
                if (w_wdreq) begin
                    r_req_cnt <= r_req_cnt + 5'd1;
                end
                if (w_pop) begin
                    r_wr_cnt <= r_wr_cnt + 5'd1;
                end
            end

            // Initiator data is valid exactly one cycle after the pull.
            r_in_flight <= w_wdreq;
            if (r_in_flight) begin
                if (r_tail) begin
                    r_buf1 <= acp_tx_wdata;
                end else begin
                    r_buf0 <= acp_tx_wdata;
                end
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_occ <= r_occ + {1'b0, r_in_flight} - {1'b0, w_pop};

            if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign acp_tx_rdy   = r_rdy;
    assign acp_tx_wdreq = w_wdreq;
    assign m_awaddr     = r_awaddr;
    assign m_awid       = r_awid;
    assign m_awvalid    = r_awvalid;
    assign m_wdata      = r_head ? r_buf1 : r_buf0;
    assign m_wid        = r_awid;
    assign m_wvalid     = w_wvalid;
    assign m_wlast      = w_wvalid && w_last_beat;
    assign m_bready     = (r_state == S_RESP);
    assign busy         = (r_state != S_IDLE);
    assign err_cnt      = r_err_cnt;

    // Fixed AW/W attributes read as zero while reset is held.
    assign m_awlen   = rst ? 4'd0  : 4'(BURST_LEN - 1);
    assign m_awsize  = rst ? 3'd0  : 3'b011;
    assign m_awburst = rst ? 2'd0  : 2'b01;
    assign m_wstrb   = rst ? 8'd0  : 8'hFF;
    assign m_awcache = rst ? 4'd0  : ACP_CACHE;
    assign m_awuser  = rst ? 5'd0  : ACP_USER;

endmodule

// File: doc/acp_tx_rsp.md
Name: acp_tx_rsp

Overview:
- Responder end of the acp0_tx write-request interface. It sits in the ACP bridge between the PL data mover, which acts as initiator, and the PS ACP slave port.
- It accepts one burst request, with address and ID, from the initiator and pulls exactly BURST_LEN 64-bit beats via a request/data handshake.
- It issues the burst as one AXI3 INCR write on the ACP port and checks the write response.

Parameters:
- BURST_LEN, 16, beats per request; legal range 1..16, maps to AWLEN = BURST_LEN-1.
- ACP_CACHE, 4'b1111, constant value driven on m_awcache.
- ACP_USER, 5'b00001, constant value driven on m_awuser (coherent).

Ports:
- clk125  in  1  system clock, 125 MHz.
- rst  in  1  asynchronous reset, active-high.
- acp_tx_en  in  1  initiator request; awaddr and awid are valid while high.
- acp_tx_rdy  out  1  responder can accept a request; a request is accepted on a cycle where en and rdy are both high.
- acp_tx_awaddr  in  32  burst byte address.
- acp_tx_awid  in  3  burst ID.
- acp_tx_wdata  in  64  beat data; valid exactly one cycle after the wdreq cycle.
- acp_tx_wdreq  out  1  single-cycle pull of one beat.
- m_awaddr  out  32  AXI AW address.
- m_awid  out  3  AXI AW ID.
- m_awlen  out  4  AXI AW length.
- m_awsize  out  3  AXI AW size.
- m_awburst  out  2  AXI AW burst type.
- m_awcache  out  4  AXI AW cache.
- m_awuser  out  5  AXI AW user.
- m_awvalid  out  1  AXI AW valid.
- m_awready  in  1  AXI AW ready.
- m_wdata  out  64  AXI W data.
- m_wstrb  out  8  AXI W strobe.
- m_wid  out  3  AXI W ID.
- m_wlast  out  1  AXI W last.
- m_wvalid  out  1  AXI W valid.
- m_wready  in  1  AXI W ready.
- m_bid  in  3  AXI B ID.
- m_bresp  in  2  AXI B response.
- m_bvalid  in  1  AXI B valid.
- m_bready  out  1  AXI B ready.
- busy  out  1  high from acceptance until the B handshake completes.
- err_cnt  out  16  saturating count of bad responses and misaligned requests.

Behaviour:
- Reset values: all outputs 0. FSM is IDLE, buffer is empty, counters are 0. Reset asserted mid-burst aborts immediately with no cleanup; the initiator must also be reset.
- Constant outputs: m_awsize=3'b011, m_awburst=2'b01, m_awlen=BURST_LEN-1, m_wstrb=8'hFF, m_awcache=ACP_CACHE, m_awuser=ACP_USER. These are driven only while not in reset.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - acp_tx_rdy=1 (registered).
  - On en&rdy, capture the address with bits [2:0] forced to 0, and capture the ID.
  - If awaddr[2:0]!=0, err_cnt increments.
  - Next state is ADDR; rdy drops the cycle after acceptance.
- ADDR:
  - m_awvalid=1 with the captured address and ID, held stable until m_awready.
  - On handshake, go to DATA.
  - Zero-cycle AW handshake is impossible because awvalid is registered.
- DATA:
  - Uses a 2-entry beat buffer and two counters: req_cnt (wdreq issued) and in_flight (wdreq issued last cycle, data not yet captured).
  - Assert wdreq when req_cnt<BURST_LEN and (occupancy + in_flight + pending W pop) leaves room, i.e. occupancy+in_flight<2 after accounting for a same-cycle W handshake.
  - Sustained throughput is 1 beat/clk when m_wready is held high.
  - acp_tx_wdata is written into the buffer on the cycle after wdreq, unconditionally.
  - m_wvalid is high whenever the buffer is non-empty. m_wdata is the buffer head and m_wid is the captured ID.
  - m_wlast=1 on the beat whose index is BURST_LEN-1; W beats are counted in wr_cnt.
  - A simultaneous buffer write and W pop keeps occupancy unchanged.
  - After the last W handshake, go to RESP.
  - wdreq never exceeds BURST_LEN pulses per burst.
- RESP:
  - m_bready=1.
  - On m_bvalid, if bresp!=2'b00 or bid!=captured ID, err_cnt increments.
  - Next state is IDLE; rdy returns high the following cycle.
- err_cnt saturates at 16'hFFFF. Two error sources cannot fire in the same cycle because they occur in different states.
- busy=1 in ADDR, DATA and RESP.
- en while not rdy is ignored; the initiator holds it.
- Minimum burst time, with ready signals tied high, is 1 (accept) + 1 (AW) + BURST_LEN + 2 (W pipeline) + 1 (B) cycles.

Test Plan:
- Nominal burst: awready/wready/bvalid tied high, BURST_LEN=16, request addr=0x1000_0040, id=3, data=beat index → one AW with addr 0x1000_0040, len 15, id 3; 16 W beats 0..15; wlast only on beat 15; exactly 16 wdreq pulses; err_cnt=0; rdy returns within 21 cycles.
- W backpressure: wready toggles 1,0,0,1 pattern → no beat lost or duplicated; wdata order is 0..15; wdreq is never issued while the buffer is full with one beat in flight.
- Bad response: bresp=2'b10 on B → err_cnt=1, FSM returns to IDLE. Then bid=5 with expected id=3 → err_cnt=2.
- Misaligned address: request addr=0x2000_0005 → m_awaddr=0x2000_0000, err_cnt increments by 1, burst completes normally.
- Reset mid-burst: assert rst after beat 7 → all outputs 0 asynchronously; after release rdy=1 and a new burst completes correctly with 16 beats.
- BURST_LEN=1 build: m_awlen=0, a single beat with wlast=1, one wdreq pulse.
